wt_cpa_seq: RTL and testbench
=============================

// Module: wt_cpa_seq
// PURPOSE
//   Sequential carry-propagate adder at the output of the Wallace-tree reduction.
//   Takes the final sum/carry rows from the 5:2 compressor layer and adds them into
//   a single binary product.
//   Sums one SLICE-bit chunk per cycle, LSB first, with a registered inter-slice carry.
//   Uses a valid/ready handshake on input and output.
// PARAMETERS
//   WIDTH  24  row/product width in bits; WIDTH % SLICE must be 0
//   SLICE   8  bits added per cycle; NS = WIDTH/SLICE is the number of add cycles
// PORTS
//   clk        in   1      rising-edge clock, the only clock
//   reset      in   1      synchronous, active-high reset
//   in_valid   in   1      sum_vec/carry_vec are valid
//   in_ready   out  1      block can accept a new operand pair
//   sum_vec    in   WIDTH  sum row, bit i has weight 2^i
//   carry_vec  in   WIDTH  carry row, bit i has weight 2^(i+1); block shifts it internally
//   out_valid  out  1      product/ovf are valid
//   out_ready  in   1      consumer accepts product
//   product    out  WIDTH  (sum_vec + (carry_vec<<1)) mod 2^WIDTH
//   ovf        out  1      true result >= 2^WIDTH
// BEHAVIOUR
//   Reset
//     - State goes to IDLE; in_ready=1; out_valid=0; product=0; ovf=0.
//     - Slice index and slice carry are cleared.
//     - Reset in any state aborts the operation in progress; no output is produced for it.
//   FSM: IDLE -> ADD -> DONE -> IDLE
//   IDLE
//     - in_ready=1.
//     - On in_valid&in_ready: latch A=sum_vec and B={carry_vec[WIDTH-2:0],1'b0}.
//     - Latch hi=carry_vec[WIDTH-1]; clear carry register, slice idx=0, product accumulator.
//     - Go to ADD.
//   ADD
//     - in_ready=0.
//     - Each cycle: {c, P[idx]} = A[idx] + B[idx] + c, where [idx] is bits idx*SLICE +: SLICE.
//     - Then idx++.
//     - After slice NS-1: ovf = c_out | hi. Go to DONE.
//     - Exactly NS cycles are spent in ADD.
//   DONE
//     - out_valid=1; product and ovf are held stable while out_ready=0.
//     - On out_ready: next state IDLE; out_valid drops on the following cycle.
//     - product/ovf keep their last value until the next operation completes.
//   Latency
//     - Acceptance at clock edge k.
//     - out_valid is first high in the cycle after edge k+NS (NS+1 cycles with WIDTH=24, SLICE=8).
//   Throughput
//     - One result per NS+2 cycles when out_ready is tied high.
//     - No accept in the same cycle as the out handshake: in_ready=0 in DONE.
//   Inputs
//     - Inputs are sampled only at acceptance.
//     - Changes to sum_vec/carry_vec during ADD/DONE have no effect.
//   in_valid
//     - in_valid while not in IDLE is ignored (the producer must hold it until in_ready).
//   Edge cases
//     - All-ones operands must propagate carry across every slice boundary correctly.
//     - ovf is 0 for any legal 8x16 tree output; ovf=1 flags a reduction-tree fault.
// TESTING (WIDTH=24, SLICE=8)
//   1. sum=0x00FFFF, carry=0x000001
//      -> product=0x010001, ovf=0; out_valid exactly NS+1=4 cycles after accept.
//   2. sum=0xFFFFFF, carry=0x000001 (carry ripples through all 3 slices)
//      -> product=0x000001, ovf=1.
//   3. sum=0x000000, carry=0x800000 (MSB of carry row)
//      -> product=0x000000, ovf=1.
//   4. Backpressure: test 1 with out_ready=0 for 5 cycles
//      -> out_valid stays 1, product stable at 0x010001, in_ready=0.
//      -> Release out_ready: IDLE the next cycle.
//   5. reset=1 for 1 cycle during the second ADD cycle
//      -> next cycle in_ready=1, out_valid=0, product=0.
//      -> Next operation (sum=5, carry=1) -> product=0x000007.
//   6. 1000 random sum/carry pairs with random out_ready
//      -> product/ovf match the golden model sum+(carry<<1).
//      -> No result is lost or duplicated.

Source files
------------

// File: rtl/wt_cpa_seq.sv
// wt_cpa_seq: sequential carry-propagate adder for the Wallace-tree output rows.
// Adds the sum row and the (left-shifted) carry row SLICE bits per cycle, LSB
// slice first, with the inter-slice carry kept in a register. Valid/ready on
// both the operand side and the result side.
module wt_cpa_seq #(
  parameter int WIDTH = 24,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sum_vec,
  input  logic [WIDTH-1:0] carry_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] product,
  output logic             ovf
);

  // WIDTH must be a multiple of SLICE; NS slices are added, one per cycle.
  localparam int NS   = WIDTH / SLICE;
  localparam int IDXW = (NS > 1) ? $clog2(NS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [WIDTH-1:0]  a_reg;        // latched sum row
  logic [WIDTH-1:0]  b_reg;        // latched carry row, already shifted by one
  logic              hi_reg;       // carry-row MSB that falls off the shift
  logic              c_reg;        // carry between slices
  logic [IDXW-1:0]   idx_reg;      // slice currently being added
  logic [WIDTH-1:0]  acc_reg;      // partial product built slice by slice
  logic [WIDTH-1:0]  product_reg;
  logic              ovf_reg;

  logic [SLICE-1:0]  a_sl [NS];
  logic [SLICE-1:0]  b_sl [NS];
  logic [SLICE-1:0]  a_cur;
  logic [SLICE-1:0]  b_cur;
  logic [SLICE:0]    slice_sum;
  logic [WIDTH-1:0]  acc_next;
  logic              last_slice;
  logic              accept;

  assign accept     = in_valid && (state_reg == IDLE);
  assign last_slice = (idx_reg == IDXW'(NS - 1));

  // Split the operands into slices and build the next accumulator value, where
  // only the slice selected by idx_reg is replaced by the fresh slice sum.
  genvar gi;
  generate
    for (gi = 0; gi < NS; gi++) begin : g_slice
      localparam logic [IDXW-1:0] GI_IDX = IDXW'(gi);
      assign a_sl[gi] = a_reg[gi*SLICE +: SLICE];
      assign b_sl[gi] = b_reg[gi*SLICE +: SLICE];
      assign acc_next[gi*SLICE +: SLICE] =
        (idx_reg == GI_IDX) ? slice_sum[SLICE-1:0] : acc_reg[gi*SLICE +: SLICE];
    end
  endgenerate

  // Select the operand slices for the current add cycle.
  always_comb begin
    a_cur = '0;
    b_cur = '0;
    for (int i = 0; i < NS; i++) begin
      if (idx_reg == IDXW'(i)) begin
        a_cur = a_sl[i];
        b_cur = b_sl[i];
      end
    end
  end

  // One SLICE-bit add with the registered carry-in; MSB is the carry-out.
  assign slice_sum = {1'b0, a_cur} + {1'b0, b_cur} + {{SLICE{1'b0}}, c_reg};

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = ADD;
      end
      ADD: begin
        if (last_slice) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, add one slice per ADD cycle, and
  // publish product/ovf only when the final slice is done so the visible
  // result never shows a half-built value.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg       <= '0;
      b_reg       <= '0;
      hi_reg      <= 1'b0;
      c_reg       <= 1'b0;
      idx_reg     <= '0;
      acc_reg     <= '0;
      product_reg <= '0;
      ovf_reg     <= 1'b0;
    end else if (accept) begin
      a_reg   <= sum_vec;
      b_reg   <= {carry_vec[WIDTH-2:0], 1'b0};
      hi_reg  <= carry_vec[WIDTH-1];
      c_reg   <= 1'b0;
      idx_reg <= '0;
      acc_reg <= '0;
    end else if (state_reg == ADD) begin
      c_reg   <= slice_sum[SLICE];
      idx_reg <= idx_reg + IDXW'(1);
      acc_reg <= acc_next;
      if (last_slice) begin
        product_reg <= acc_next;
        // A carry out of the top slice or a dropped carry-row MSB both mean
        // the true sum does not fit in WIDTH bits.
        ovf_reg     <= slice_sum[SLICE] | hi_reg;
      end
    end
  end

  assign product = product_reg;
  assign ovf     = ovf_reg;

endmodule

// File: tb/tb_wt_cpa_seq.sv
// tb_wt_cpa_seq: directed and random checks of wt_cpa_seq (WIDTH=24, SLICE=8).
// The driver pushes the expected result into a scoreboard queue when it issues
// an operand pair; an independent monitor pops and compares on every output
// handshake.
module tb_wt_cpa_seq;

  localparam int WIDTH = 24;
  localparam int SLICE = 8;
  localparam int NS    = WIDTH / SLICE;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] sum_vec = '0;
  logic [WIDTH-1:0] carry_vec = '0;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] product;
  logic             ovf;

  typedef struct {
    logic [WIDTH-1:0] p;
    logic             o;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  int   pushed = 0;
  int   popped = 0;
  int   ready_mode = 0;   // 0: ready high, 1: ready low, 2: random

  wt_cpa_seq #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum_vec   (sum_vec),
    .carry_vec (carry_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Consumer side: out_ready changes just after the rising edge.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: a handshake seen at the falling edge completes on the next rise.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_output", 32'(product), 32'hFFFF_FFFF);
        end else begin
          e = sb_q.pop_front();
          popped++;
          $display("out #%0d: product=0x%06h ovf=%0d (exp 0x%06h %0d)",
                   popped, product, ovf, e.p, e.o);
          check("product", 32'(product), 32'(e.p));
          check("ovf", 32'(ovf), 32'(e.o));
        end
      end
    end
  end

  // Issue one operand pair; returns just after the accepting edge.
  task automatic send(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c,
                      input bit expect_out);
    logic [WIDTH+1:0] full;
    exp_t e;
    int n;
    full = {2'b00, s} + {1'b0, c, 1'b0};
    if (expect_out) begin
      e.p = full[WIDTH-1:0];
      e.o = |full[WIDTH+1:WIDTH];
      sb_q.push_back(e);
      pushed++;
    end
    @(posedge clk);
    #1;
    sum_vec   = s;
    carry_vec = c;
    in_valid  = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 100);
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    sum_vec   = 24'($urandom);   // must be ignored after acceptance
    carry_vec = 24'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset and initial state
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_product", 32'(product), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);

    // 1: basic add and latency
    send(24'h00FFFF, 24'h000001, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!out_valid) check("add_in_ready_low", 32'(in_ready), 32'd0);
    end while (!out_valid && n < 20);
    check("latency", 32'(n), 32'(NS + 1));
    drain();

    // 2: carry ripples through every slice
    send(24'hFFFFFF, 24'h000001, 1'b1);
    drain();
    // 3: carry-row MSB shifts out
    send(24'h000000, 24'h800000, 1'b1);
    drain();
    // extra directed vectors
    send(24'hFFFFFF, 24'h7FFFFF, 1'b1);   // 0x1FFFFFD
    drain();
    send(24'h123456, 24'h000100, 1'b1);   // 0x123656
    drain();

    // 4: backpressure
    ready_mode = 1;
    send(24'h00FFFF, 24'h000001, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    check("bp_reach_done", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_product", 32'(product), 32'h010001);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    ready_mode = 0;
    n = 0;
    while (!(out_valid && out_ready) && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("bp_release", 32'(out_ready), 32'd1);
    @(negedge clk);
    check("bp_idle_in_ready", 32'(in_ready), 32'd1);
    check("bp_idle_out_valid", 32'(out_valid), 32'd0);
    drain();

    // 5: reset during the second ADD cycle aborts the operation
    send(24'h111111, 24'h000111, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_product", 32'(product), 32'd0);
    send(24'h000005, 24'h000001, 1'b1);
    drain();

    // 6: random operands with random consumer backpressure
    ready_mode = 2;
    for (int i = 0; i < 1000; i++) begin
      send(24'($urandom), 24'($urandom), 1'b1);
    end
    drain();
    ready_mode = 0;
    repeat (5) @(negedge clk);
    check("results_count", 32'(popped), 32'(pushed));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
